uart_rx_cmd_fifo: RTL and testbench
===================================

Name: uart_rx_cmd_fifo

Overview:
- Synthesizable, parametrised UART receiver for the UART-to-I2C bridge front end.
- Oversamples the serial line at 16x, reassembles LSB-first frames and classifies each byte as a bridge command or payload data.
- Buffers the byte and its command tag in an internal FIFO and presents them on a valid/ready stream to the downstream I2C/GPIO command sequencer.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..8.
- FIFO_DEPTH, 16, FIFO entries; power of 2, minimum 2.
- DIV_W, 16, width of the baud divisor input.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- baud_div  in  DIV_W  clk cycles per oversample tick; 0 is treated as 1; sampled live.
- parity_odd  in  1  1 = odd parity, 0 = even; ignored unless the optional feature is compiled in.
- rx  in  1  asynchronous serial input; idles high.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  consumer accepts the head.
- out_data  out  DATA_BITS  received byte at the FIFO head.
- out_cmd  out  3  cmd_e tag of the head entry.
- fifo_count  out  $clog2(FIFO_DEPTH+1)  current occupancy.
- overflow  out  1  one-cycle pulse: a good byte was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- parity_err  out  1  one-cycle pulse: parity mismatch.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_cmd=CMD_DATA, fifo_count=0, overflow/frame_err/parity_err=0.
  - Internal state on reset: synchronizer flops=1, FSM=IDLE, all counters=0.
  - Reset asserted mid-frame abandons the frame with no push and no error pulse.
- rx input conditioning: 2-flop synchronizer; all decisions use the synchronized value rx_s.
- Tick generator: down-counter reloads with max(baud_div,1)-1 and emits a 1-clk tick on reaching 0.
- FSM states: IDLE, START, DATA, STOP, BREAK (plus PARITY with the optional feature). A 4-bit sample counter advances on ticks; mid-bit = sample 7 for the start bit, sample 15 thereafter.
  - IDLE: rx_s==0 -> START; sample counter cleared; tick counter reloaded.
  - START: at sample 7, rx_s==0 -> DATA; rx_s==1 -> IDLE (glitch; no error).
  - DATA: every 16 ticks, shift rx_s into bit[i], LSB first; after DATA_BITS bits -> STOP (or PARITY).
  - STOP: mid-bit rx_s==1 -> push request, then IDLE.
  - STOP: mid-bit rx_s==0 -> frame_err pulse, byte discarded, -> BREAK.
  - BREAK: waits for rx_s==1, then -> IDLE.
- Command classification (DATA_BITS==8 only; otherwise always CMD_DATA):
  - 0x53 CMD_START, 0x50 CMD_STOP, 0x52 CMD_READ, 0x57 CMD_WRITE, 0x49 CMD_GPIO_RD, 0x4F CMD_GPIO_WR, 0x5A CMD_PWRDN.
  - Any other value -> CMD_DATA.
  - The tag is stored in the FIFO alongside the byte.
- FIFO write: push occurs 1 clk after the stop-bit mid-sample.
  - Empty FIFO: out_valid rises on the following clk (no fall-through).
- FIFO read: pop when out_valid && out_ready. Head data/tag are registered and stable while out_valid && !out_ready.
- Full FIFO:
  - Push without a same-cycle pop -> byte dropped, overflow pulse, FIFO contents unchanged.
  - Push with a same-cycle pop -> push accepted; count unchanged.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is updated the same cycle as each push/pop.
- Receiver never stalls on back-pressure; back-to-back frames with no idle time are supported.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: PARITY state is inserted after DATA and samples one parity bit.
  - Parity is computed over DATA_BITS per parity_odd.
  - Mismatch -> parity_err pulse at the stop-bit mid-sample; byte not pushed; FSM continues to STOP normally.
  - If parity and stop bit both fail, both pulses fire in the same cycle.
- Undefined: no parity bit; parity_odd ignored; parity_err tied 0.

Decomposition:
- Package uart_bridge_pkg holds:
  - cmd_e: 3-bit enum CMD_DATA=0, CMD_START, CMD_STOP, CMD_READ, CMD_WRITE, CMD_GPIO_RD, CMD_GPIO_WR, CMD_PWRDN.
  - ASCII command constants.
  - function classify(byte) -> cmd_e.
- Sub-module sync_fifo is parametrised on WIDTH and DEPTH; stores {cmd, data} and provides count/full/empty.
- FSM and tick generator remain in the top module.

Test Plan:
- Common setup: clk 100 MHz, baud_div=54 (~115200 baud).
- Send frame 0x53 -> one entry: out_data=0x53, out_cmd=CMD_START, out_valid high 1 clk after stop mid-bit; no error pulses.
- Send 0x41, 0x57, 0x5A back-to-back with out_ready=1 -> tags CMD_DATA, CMD_WRITE, CMD_PWRDN, in order; fifo_count never exceeds 1.
- 4-tick low glitch on rx -> FSM back to IDLE; no push, no error; then 0x50 is received correctly with CMD_STOP.
- Send 0x57 with stop bit driven 0 for 2 bit times -> frame_err pulse, no push, FSM held in BREAK until rx=1; next frame 0x52 received with CMD_READ.
- FIFO_DEPTH=4, out_ready=0, send 0x01..0x05:
  - fifo_count=4; overflow pulses on the 5th byte.
  - Drain returns 0x01..0x04.
  - A pop coincident with a push on the full FIFO keeps count at 4.
- Assert rst_n low during data bit 3, release, send 0x4F -> all outputs at reset values during reset; only 0x4F/CMD_GPIO_WR is received afterwards.
  - With UART_RX_PARITY_EN and parity_odd=0: a bad parity bit on 0x49 -> parity_err pulse and no push.

Source files
------------

// File: rtl/uart_bridge_pkg.sv
// -----------------------------------------------------------------------------
// uart_bridge_pkg
// Shared types for the UART-to-I2C bridge front end:
//   - cmd_e    : 3-bit tag attached to every received byte
//   - ASCII_*  : command byte values recognised by the bridge
//   - state_e  : receiver FSM states (PARITY only when UART_RX_PARITY_EN is set)
//   - classify : maps an 8-bit byte onto its cmd_e tag
// Optional build macro: UART_RX_PARITY_EN (adds the PARITY receiver state).
// -----------------------------------------------------------------------------
package uart_bridge_pkg;

    typedef enum logic [2:0] {
        CMD_DATA    = 3'd0,
        CMD_START   = 3'd1,
        CMD_STOP    = 3'd2,
        CMD_READ    = 3'd3,
        CMD_WRITE   = 3'd4,
        CMD_GPIO_RD = 3'd5,
        CMD_GPIO_WR = 3'd6,
        CMD_PWRDN   = 3'd7
    } cmd_e;

    localparam logic [7:0] ASCII_START   = 8'h53;  // 'S'
    localparam logic [7:0] ASCII_STOP    = 8'h50;  // 'P'
    localparam logic [7:0] ASCII_READ    = 8'h52;  // 'R'
    localparam logic [7:0] ASCII_WRITE   = 8'h57;  // 'W'
    localparam logic [7:0] ASCII_GPIO_RD = 8'h49;  // 'I'
    localparam logic [7:0] ASCII_GPIO_WR = 8'h4F;  // 'O'
    localparam logic [7:0] ASCII_PWRDN   = 8'h5A;  // 'Z'

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } state_e;
`endif

    function automatic cmd_e classify(input logic [7:0] b);
        cmd_e c;
        case (b)
            ASCII_START:   c = CMD_START;
            ASCII_STOP:    c = CMD_STOP;
            ASCII_READ:    c = CMD_READ;
            ASCII_WRITE:   c = CMD_WRITE;
            ASCII_GPIO_RD: c = CMD_GPIO_RD;
            ASCII_GPIO_WR: c = CMD_GPIO_WR;
            ASCII_PWRDN:   c = CMD_PWRDN;
            default:       c = CMD_DATA;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered storage; head entry is read directly from
// the storage array so it is stable until popped (no fall-through).
//   clk, rst_n : clock, asynchronous active-low reset (storage cleared to 0)
//   push_i     : write wdata_i; accepted when not full, or full with a pop
//   pop_i      : remove head; ignored when empty
//   wdata_i    : entry to write
//   rdata_o    : head entry
//   count_o    : occupancy, updated on the same edge as each push/pop
//   full_o     : count_o == DEPTH
//   empty_o    : count_o == 0
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic                       pop_i,
    input  logic [WIDTH-1:0]           wdata_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push_s;
    logic             do_pop_s;

    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign empty_o   = (count_q == {CNT_W{1'b0}});
    assign do_pop_s  = pop_i & ~empty_o;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_push_s = push_i & (~full_o | do_pop_s);
    assign rdata_o   = mem_q[rd_ptr_q];
    assign count_o   = count_q;

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cmd_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_cmd_fifo
// 16x-oversampling UART receiver that tags each byte as a bridge command or
// payload and queues {tag, byte} for the downstream command sequencer.
//   clk, rst_n  : clock, asynchronous active-low reset
//   baud_div    : clk cycles per oversample tick (0 behaves as 1), used live
//   parity_odd  : 1 = odd, 0 = even parity (only with UART_RX_PARITY_EN)
//   rx          : asynchronous serial input, idle high
//   out_valid / out_ready / out_data / out_cmd : head-of-FIFO stream
//   fifo_count  : FIFO occupancy
//   overflow    : pulse, good byte dropped on a full FIFO
//   frame_err   : pulse, stop bit sampled low
//   parity_err  : pulse, parity mismatch (tied 0 unless UART_RX_PARITY_EN)
// Optional build macro: UART_RX_PARITY_EN (one parity bit after the data bits).
// -----------------------------------------------------------------------------
module uart_rx_cmd_fifo
    import uart_bridge_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int DIV_W      = 16
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [DIV_W-1:0]                baud_div,
    input  logic                            parity_odd,
    input  logic                            rx,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [DATA_BITS-1:0]            out_data,
    output logic [2:0]                      out_cmd,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            overflow,
    output logic                            frame_err,
    output logic                            parity_err
);

    localparam int ENT_W = DATA_BITS + 3;

    logic                 sync1_q;
    logic                 rx_s;
    logic [DIV_W-1:0]     tick_cnt_q, tick_cnt_d, reload_s;
    logic                 tick_s, restart_s;
    state_e               state_q, state_d;
    logic [3:0]           samp_q, samp_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 push_q, push_d;
    logic                 ferr_q, ferr_d;
    logic                 ovf_q;
    logic                 par_bad_s;
    cmd_e                 cmd_s;
    logic                 pop_s, full_s, empty_s;
    logic [ENT_W-1:0]     head_s;

`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_q, perr_d;
    // Mismatch when the received bit differs from the required parity bit.
    assign par_bad_s  = par_q ^ (^shift_q) ^ parity_odd;
    assign parity_err = perr_q;
`else
    logic                 unused_parity_s;
    assign unused_parity_s = parity_odd;
    assign par_bad_s  = 1'b0;
    assign parity_err = 1'b0;
`endif

    generate
        if (DATA_BITS == 8) begin : g_classify
            assign cmd_s = classify(shift_q);
        end else begin : g_no_classify
            assign cmd_s = CMD_DATA;
        end
    endgenerate

    assign reload_s = (baud_div == {DIV_W{1'b0}}) ? {DIV_W{1'b0}}
                                                  : baud_div - DIV_W'(1);
    assign tick_s   = (tick_cnt_q == {DIV_W{1'b0}});

    // Oversample tick down-counter; realigned to the start-bit edge.
    always_comb begin
        tick_cnt_d = tick_cnt_q - DIV_W'(1);
        if (restart_s || tick_s) begin
            tick_cnt_d = reload_s;
        end else begin
            tick_cnt_d = tick_cnt_q - DIV_W'(1);
        end
    end

    // Receiver next-state: start qualification, bit sampling, stop check.
    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        push_d    = 1'b0;
        ferr_d    = 1'b0;
        restart_s = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d     = par_q;
        perr_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                samp_d = 4'd0;
                bit_d  = 3'd0;
                if (!rx_s) begin
                    state_d   = ST_START;
                    restart_s = 1'b1;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s) begin
                    if (samp_q == 4'd7) begin
                        samp_d  = 4'd0;
                        // A start bit that is high again at mid-bit was a glitch.
                        state_d = rx_s ? ST_IDLE : ST_DATA;
                    end else begin
                        samp_d  = samp_q + 4'd1;
                    end
                end else begin
                    samp_d = samp_q;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    samp_d = samp_q + 4'd1;
                    if (samp_q == 4'd15) begin
                        shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
                        if (bit_q == 3'(DATA_BITS - 1)) begin
                            bit_d   = 3'd0;
`ifdef UART_RX_PARITY_EN
                            state_d = ST_PARITY;
`else
                            state_d = ST_STOP;
`endif
                        end else begin
                            bit_d   = bit_q + 3'd1;
                        end
                    end else begin
                        shift_d = shift_q;
                    end
                end else begin
                    samp_d = samp_q;
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (tick_s) begin
                    samp_d = samp_q + 4'd1;
                    if (samp_q == 4'd15) begin
                        par_d   = rx_s;
                        state_d = ST_STOP;
                    end else begin
                        par_d   = par_q;
                    end
                end else begin
                    samp_d = samp_q;
                end
            end
`endif
            ST_STOP: begin
                if (tick_s) begin
                    samp_d = samp_q + 4'd1;
                    if (samp_q == 4'd15) begin
`ifdef UART_RX_PARITY_EN
                        perr_d = par_bad_s;
`endif
                        if (rx_s) begin
                            push_d  = ~par_bad_s;
                            state_d = ST_IDLE;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = ST_BREAK;
                        end
                    end else begin
                        state_d = ST_STOP;
                    end
                end else begin
                    samp_d = samp_q;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_BREAK;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Synchronizer, tick counter, FSM state and registered pulse outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            rx_s       <= 1'b1;
            tick_cnt_q <= {DIV_W{1'b0}};
            state_q    <= ST_IDLE;
            samp_q     <= 4'd0;
            bit_q      <= 3'd0;
            shift_q    <= {DATA_BITS{1'b0}};
            push_q     <= 1'b0;
            ferr_q     <= 1'b0;
            ovf_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_q      <= 1'b0;
            perr_q     <= 1'b0;
`endif
        end else begin
            sync1_q    <= rx;
            rx_s       <= sync1_q;
            tick_cnt_q <= tick_cnt_d;
            state_q    <= state_d;
            samp_q     <= samp_d;
            bit_q      <= bit_d;
            shift_q    <= shift_d;
            push_q     <= push_d;
            ferr_q     <= ferr_d;
            ovf_q      <= push_q & full_s & ~pop_s;
`ifdef UART_RX_PARITY_EN
            par_q      <= par_d;
            perr_q     <= perr_d;
`endif
        end
    end

    assign pop_s = ~empty_s & out_ready;

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_q),
        .pop_i   (pop_s),
        .wdata_i ({cmd_s, shift_q}),
        .rdata_o (head_s),
        .count_o (fifo_count),
        .full_o  (full_s),
        .empty_o (empty_s)
    );

    assign out_valid = ~empty_s;
    assign out_data  = head_s[DATA_BITS-1:0];
    assign out_cmd   = head_s[ENT_W-1:DATA_BITS];
    assign overflow  = ovf_q;
    assign frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx_cmd_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_cmd_fifo
// Directed bench for uart_rx_cmd_fifo (FIFO_DEPTH = 4). Frames are driven
// aligned to clk; push timing is derived from the receiver's sampling plan:
// rx falls after edge k, the FIFO write happens on edge k + 4 + SLOTS*div.
// Honours UART_RX_PARITY_EN (adds a parity bit to every frame).
// -----------------------------------------------------------------------------
module tb_uart_rx_cmd_fifo;

`ifdef UART_RX_PARITY_EN
    localparam int SLOTS = 168;
`else
    localparam int SLOTS = 152;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] baud_div = 16'd54;
    logic        parity_odd = 1'b0;
    logic        rx = 1'b1;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [7:0]  out_data;
    logic [2:0]  out_cmd;
    logic [2:0]  fifo_count;
    logic        overflow, frame_err, parity_err;

    int checks = 0;
    int errors = 0;

    int ferr_n = 0, perr_n = 0, ovf_n = 0, gt1_n = 0, rcv_n = 0;
    logic [10:0] rcv_mem [64];

    uart_rx_cmd_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4), .DIV_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .baud_div(baud_div), .parity_odd(parity_odd),
        .rx(rx), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_cmd(out_cmd), .fifo_count(fifo_count), .overflow(overflow),
        .frame_err(frame_err), .parity_err(parity_err)
    );

    always #5 clk = ~clk;

    // Pulse counters and record of every accepted {tag, byte}.
    always @(negedge clk) begin
        if (frame_err)  ferr_n <= ferr_n + 1;
        if (parity_err) perr_n <= perr_n + 1;
        if (overflow)   ovf_n  <= ovf_n + 1;
        if (fifo_count > 3'd1) gt1_n <= gt1_n + 1;
        if (out_valid && out_ready) begin
            rcv_mem[rcv_n % 64] <= {out_cmd, out_data};
            rcv_n <= rcv_n + 1;
        end
    end

    // Must be called right after a posedge (+#1); returns at posedge + #1.
    task automatic send_frame(input logic [7:0] b, input int bitc, input logic bad_par,
                              input logic stop_val, input int stop_bits);
        rx = 1'b0;
        repeat (bitc) @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (bitc) @(posedge clk);
            #1;
        end
`ifdef UART_RX_PARITY_EN
        rx = (^b) ^ parity_odd ^ bad_par;
        repeat (bitc) @(posedge clk);
        #1;
`else
        if (bad_par) rx = 1'b1; else rx = 1'b1;
`endif
        rx = stop_val;
        repeat (bitc * stop_bits) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (5) @(posedge clk);
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
        checks++; if (out_cmd !== 3'd0) begin errors++; $display("FAIL reset_cmd: got %0d want 0", out_cmd); end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        checks++; if ({overflow, frame_err, parity_err} !== 3'b000) begin errors++; $display("FAIL reset_pulses: got %b want 000", {overflow, frame_err, parity_err}); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_single();
        int f0, p0;
        f0 = ferr_n; p0 = perr_n;
        baud_div = 16'd54; out_ready = 1'b0;
        @(posedge clk); #1;
        fork
            send_frame(8'h53, 16 * 54, 1'b0, 1'b1, 1);
            begin
                repeat (3 + SLOTS * 54) @(posedge clk);
                @(negedge clk);
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early: valid=%b want 0", out_valid); end
                @(negedge clk);
                checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_latency: valid=%b want 1", out_valid); end
            end
        join
        checks++; if (out_data !== 8'h53) begin errors++; $display("FAIL single_data: got %h want 53", out_data); end
        checks++; if (out_cmd !== 3'd1) begin errors++; $display("FAIL single_cmd: got %0d want 1", out_cmd); end
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        checks++; if (ferr_n != f0 || perr_n != p0) begin errors++; $display("FAIL single_errs: frame %0d parity %0d want 0 0", ferr_n - f0, perr_n - p0); end
        @(posedge clk); #1 out_ready = 1'b1;
        @(posedge clk); #1 out_ready = 1'b0;
        @(negedge clk);
        checks++; if (fifo_count !== 3'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL single_pop: count %0d valid %b want 0 0", fifo_count, out_valid); end
    endtask

    task automatic test_back_to_back();
        int base, g0;
        logic [10:0] exp_e [3];
        exp_e[0] = {3'd0, 8'h41}; exp_e[1] = {3'd4, 8'h57}; exp_e[2] = {3'd7, 8'h5A};
        base = rcv_n; g0 = gt1_n;
        baud_div = 16'd3; out_ready = 1'b1;
        @(posedge clk); #1;
        send_frame(8'h41, 48, 1'b0, 1'b1, 1);
        send_frame(8'h57, 48, 1'b0, 1'b1, 1);
        send_frame(8'h5A, 48, 1'b0, 1'b1, 1);
        repeat (20) @(posedge clk);
        checks++; if (rcv_n - base != 3) begin errors++; $display("FAIL b2b_num: got %0d want 3", rcv_n - base); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (rcv_mem[(base + i) % 64] !== exp_e[i]) begin errors++; $display("FAIL b2b_entry%0d: got %h want %h", i, rcv_mem[(base + i) % 64], exp_e[i]); end
        end
        checks++; if (gt1_n != g0) begin errors++; $display("FAIL b2b_count: count exceeded 1 for %0d cycles want 0", gt1_n - g0); end
    endtask

    task automatic test_glitch();
        int base, f0, p0;
        base = rcv_n; f0 = ferr_n; p0 = perr_n;
        baud_div = 16'd3; out_ready = 1'b1;
        @(posedge clk); #1 rx = 1'b0;
        repeat (12) @(posedge clk);
        #1 rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        checks++; if (rcv_n != base || fifo_count !== 3'd0) begin errors++; $display("FAIL glitch_push: got %0d entries want 0", rcv_n - base); end
        checks++; if (ferr_n != f0 || perr_n != p0) begin errors++; $display("FAIL glitch_errs: frame %0d parity %0d want 0 0", ferr_n - f0, perr_n - p0); end
        send_frame(8'h50, 48, 1'b0, 1'b1, 1);
        repeat (20) @(posedge clk);
        checks++; if (rcv_n - base != 1 || rcv_mem[base % 64] !== {3'd2, 8'h50}) begin errors++; $display("FAIL glitch_next: got %0d entries head %h want 1 250", rcv_n - base, rcv_mem[base % 64]); end
    endtask

    task automatic test_break();
        int base, f0;
        base = rcv_n; f0 = ferr_n;
        baud_div = 16'd3; out_ready = 1'b1;
        @(posedge clk); #1;
        send_frame(8'h57, 48, 1'b0, 1'b0, 2);
        repeat (40 * 48) @(posedge clk);
        checks++; if (ferr_n - f0 != 1) begin errors++; $display("FAIL break_ferr: got %0d pulses want 1", ferr_n - f0); end
        checks++; if (rcv_n != base) begin errors++; $display("FAIL break_push: got %0d entries want 0", rcv_n - base); end
        #1 rx = 1'b1;
        repeat (48) @(posedge clk);
        #1;
        send_frame(8'h52, 48, 1'b0, 1'b1, 1);
        repeat (20) @(posedge clk);
        checks++; if (rcv_n - base != 1 || rcv_mem[base % 64] !== {3'd3, 8'h52}) begin errors++; $display("FAIL break_next: got %0d entries head %h want 1 352", rcv_n - base, rcv_mem[base % 64]); end
        checks++; if (ferr_n - f0 != 1) begin errors++; $display("FAIL break_ferr_after: got %0d pulses want 1", ferr_n - f0); end
    endtask

    task automatic test_overflow();
        int base, o0;
        logic [7:0] exp_d [5];
        exp_d[0] = 8'h01; exp_d[1] = 8'h02; exp_d[2] = 8'h03; exp_d[3] = 8'h04; exp_d[4] = 8'h06;
        base = rcv_n; o0 = ovf_n;
        baud_div = 16'd3; out_ready = 1'b0;
        @(posedge clk); #1;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 48, 1'b0, 1'b1, 1);
        repeat (20) @(posedge clk);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_count: got %0d want 4", fifo_count); end
        checks++; if (ovf_n - o0 != 1) begin errors++; $display("FAIL ovf_pulse: got %0d pulses want 1", ovf_n - o0); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'h01) begin errors++; $display("FAIL ovf_head: valid %b data %h want 1 01", out_valid, out_data); end
        @(posedge clk); #1;
        fork
            send_frame(8'h06, 48, 1'b0, 1'b1, 1);
            begin
                repeat (3 + SLOTS * 3) @(posedge clk);
                #1 out_ready = 1'b1;
                @(posedge clk);
                #1 out_ready = 1'b0;
            end
        join
        repeat (5) @(posedge clk);
        checks++; if (fifo_count !== 3'd4) begin errors++; $display("FAIL ovf_swap_count: got %0d want 4", fifo_count); end
        checks++; if (ovf_n - o0 != 1) begin errors++; $display("FAIL ovf_swap_pulse: got %0d pulses want 1", ovf_n - o0); end
        #1 out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        checks++; if (rcv_n - base != 5) begin errors++; $display("FAIL ovf_drain_num: got %0d want 5", rcv_n - base); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (rcv_mem[(base + i) % 64] !== {3'd0, exp_d[i]}) begin errors++; $display("FAIL ovf_drain%0d: got %h want %h", i, rcv_mem[(base + i) % 64], {3'd0, exp_d[i]}); end
        end
        checks++; if (fifo_count !== 3'd0) begin errors++; $display("FAIL ovf_empty: got %0d want 0", fifo_count); end
    endtask

    task automatic test_reset_midframe();
        int base, f0, p0;
        baud_div = 16'd3; out_ready = 1'b0;
        @(posedge clk); #1;
        send_frame(8'h57, 48, 1'b0, 1'b1, 1);
        repeat (20) @(posedge clk);
        checks++; if (fifo_count !== 3'd1) begin errors++; $display("FAIL rst_pre: count %0d want 1", fifo_count); end
        #1;
        fork
            send_frame(8'hF0, 48, 1'b0, 1'b1, 1);
            begin
                repeat (200) @(posedge clk);
                #1 rst_n = 1'b0;
                repeat (3) @(posedge clk);
                @(negedge clk);
                checks++; if (out_valid !== 1'b0 || fifo_count !== 3'd0) begin errors++; $display("FAIL rst_mid_fifo: valid %b count %0d want 0 0", out_valid, fifo_count); end
                checks++; if (out_data !== 8'h00 || out_cmd !== 3'd0) begin errors++; $display("FAIL rst_mid_head: data %h cmd %0d want 00 0", out_data, out_cmd); end
                checks++; if ({overflow, frame_err, parity_err} !== 3'b000) begin errors++; $display("FAIL rst_mid_pulses: got %b want 000", {overflow, frame_err, parity_err}); end
                repeat (45) @(posedge clk);
                #1 rst_n = 1'b1;
            end
        join
        base = rcv_n; f0 = ferr_n; p0 = perr_n;
        send_frame(8'h4F, 48, 1'b0, 1'b1, 1);
        repeat (20) @(posedge clk);
        #1 out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1 out_ready = 1'b0;
        checks++; if (rcv_n - base != 1 || rcv_mem[base % 64] !== {3'd6, 8'h4F}) begin errors++; $display("FAIL rst_after: got %0d entries head %h want 1 64f", rcv_n - base, rcv_mem[base % 64]); end
        checks++; if (ferr_n != f0 || perr_n != p0) begin errors++; $display("FAIL rst_after_errs: frame %0d parity %0d want 0 0", ferr_n - f0, perr_n - p0); end
    endtask

    task automatic test_div_zero();
        int base;
        base = rcv_n;
        baud_div = 16'd0; out_ready = 1'b1;
        @(posedge clk); #1;
        send_frame(8'h49, 16, 1'b0, 1'b1, 1);
        repeat (20) @(posedge clk);
        checks++; if (rcv_n - base != 1 || rcv_mem[base % 64] !== {3'd5, 8'h49}) begin errors++; $display("FAIL div0: got %0d entries head %h want 1 549", rcv_n - base, rcv_mem[base % 64]); end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity();
        int base, p0, f0;
        base = rcv_n; p0 = perr_n; f0 = ferr_n;
        baud_div = 16'd3; out_ready = 1'b1; parity_odd = 1'b0;
        @(posedge clk); #1;
        send_frame(8'h49, 48, 1'b1, 1'b1, 1);
        repeat (20) @(posedge clk);
        checks++; if (perr_n - p0 != 1 || ferr_n != f0) begin errors++; $display("FAIL parity_bad: parity %0d frame %0d want 1 0", perr_n - p0, ferr_n - f0); end
        checks++; if (rcv_n != base) begin errors++; $display("FAIL parity_push: got %0d entries want 0", rcv_n - base); end
        parity_odd = 1'b1;
        #1;
        send_frame(8'h49, 48, 1'b0, 1'b1, 1);
        repeat (20) @(posedge clk);
        checks++; if (rcv_n - base != 1 || perr_n - p0 != 1) begin errors++; $display("FAIL parity_odd_good: entries %0d parity %0d want 1 1", rcv_n - base, perr_n - p0); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_glitch();
        test_break();
        test_overflow();
        test_reset_midframe();
        test_div_zero();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
